// File: rtl/quad_phase_counter_pkg.sv
// Shared types and helpers for the quadrature phase-address generator:
// parameter legality check and the modular up/down step.
package quad_phase_counter_pkg;

    // Widest address or step the 33-bit modular arithmetic below can carry safely.
    localparam int CALC_MAX_W = 31;

    typedef struct packed {
        logic        wrap;
        logic [31:0] next;
    } step_res_t;

    // True when the parameter set describes a realisable table.
    function automatic logic params_legal(input int addr_w, input int step_w,
                                          input int depth, input int quad_offset);
        longint table_max;
        table_max = longint'(64'(1) << addr_w);
        return (addr_w >= 1) && (addr_w <= CALC_MAX_W) &&
               (step_w >= 1) && (step_w <= CALC_MAX_W) &&
               (depth >= 2) && (longint'(depth) <= table_max) &&
               (quad_offset >= 0) && (quad_offset < depth);
    endfunction

    // One modular step of cur by step (step < depth, cur < depth).
    // The extra carry/borrow bit keeps the intermediate exact in both directions.
    function automatic step_res_t mod_step(input logic [31:0] cur, input logic [31:0] step,
                                           input logic dir, input logic [31:0] depth);
        logic [32:0] sum;
        step_res_t   r;
        r.wrap = 1'b0;
        if (!dir) begin
            sum = {1'b0, cur} + {1'b0, step};
            if (sum >= {1'b0, depth}) begin
                sum    = sum - {1'b0, depth};
                r.wrap = 1'b1;
            end
        end else begin
            sum = {1'b0, cur} - {1'b0, step};
            if (sum[32]) begin
                sum    = sum + {1'b0, depth};
                r.wrap = 1'b1;
            end
        end
        r.next = sum[31:0];
        return r;
    endfunction

endpackage

// File: rtl/quad_phase_counter_phase_mod_step.sv
// Combinational modular add/subtract of a table address with wrap flag.
// Expects cur < DEPTH and an already saturated step < DEPTH.
module phase_mod_step
    import quad_phase_counter_pkg::*;
#(
    parameter int ADDR_W = 8,
    parameter int DEPTH  = 80
) (
    input  logic [ADDR_W-1:0] cur,
    input  logic [ADDR_W-1:0] step,
    input  logic              dir,
    output logic [ADDR_W-1:0] next,
    output logic              wrap
);

    step_res_t res;
    logic      unused_hi;

    assign res       = mod_step(32'(cur), 32'(step), dir, 32'(DEPTH));
    assign next      = res.next[ADDR_W-1:0];
    assign wrap      = res.wrap;
    // Upper bits are always zero because the result is below DEPTH.
    assign unused_hi = ^res.next[31:ADDR_W];

endmodule

// File: rtl/quad_phase_counter.sv
// Quadrature phase-address generator: sine address plus a cosine address
// leading by QUAD_OFFSET, both modulo DEPTH, with step/direction/enable,
// synchronous phase load, wrap strobe and load-error strobe.
module quad_phase_counter
    import quad_phase_counter_pkg::*;
#(
    parameter int ADDR_W      = 8,
    parameter int STEP_W      = 8,
    parameter int DEPTH       = 80,
    parameter int QUAD_OFFSET = 20
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              EN,
    input  logic              DIR,
    input  logic [STEP_W-1:0] STEP,
    input  logic              LOAD,
    input  logic [ADDR_W-1:0] LOAD_PHASE,
    output logic [ADDR_W-1:0] SIN_ADDR,
    output logic [ADDR_W-1:0] COS_ADDR,
    output logic              WRAP,
    output logic              LOAD_ERR
);

    if (!params_legal(ADDR_W, STEP_W, DEPTH, QUAD_OFFSET)) begin : g_bad_params
        $error("quad_phase_counter: illegal ADDR_W/STEP_W/DEPTH/QUAD_OFFSET combination");
    end

    localparam logic [ADDR_W-1:0] COS_RESET = ADDR_W'(QUAD_OFFSET);
    localparam logic [ADDR_W-1:0] STEP_MAX  = ADDR_W'(DEPTH - 1);

    logic [ADDR_W-1:0] sin_q, sin_d;
    logic [ADDR_W-1:0] cos_q, cos_d;
    logic              wrap_q, wrap_d;
    logic              load_err_q, load_err_d;

    logic [ADDR_W-1:0] step_sat;
    logic [ADDR_W-1:0] sin_next, cos_next;
    logic              sin_wrap;
    logic              unused_cos_wrap;
    logic              load_ok;
    step_res_t         cos_load_res;
    logic [ADDR_W-1:0] cos_load;
    logic              unused_load_bits;

    // Clamp the step so one update never moves more than a full table less one entry.
    always_comb begin
        step_sat = ADDR_W'(STEP);
        if (32'(STEP) >= 32'(DEPTH)) begin
            step_sat = STEP_MAX;
        end
    end

    phase_mod_step #(.ADDR_W(ADDR_W), .DEPTH(DEPTH)) u_sin_step (
        .cur  (sin_q),
        .step (step_sat),
        .dir  (DIR),
        .next (sin_next),
        .wrap (sin_wrap)
    );

    // The cosine runs its own modular counter; only the sine wrap is reported.
    phase_mod_step #(.ADDR_W(ADDR_W), .DEPTH(DEPTH)) u_cos_step (
        .cur  (cos_q),
        .step (step_sat),
        .dir  (DIR),
        .next (cos_next),
        .wrap (unused_cos_wrap)
    );

    // Cosine address for a load: offset added modulo the table depth.
    assign load_ok          = (32'(LOAD_PHASE) < 32'(DEPTH));
    assign cos_load_res     = mod_step(32'(LOAD_PHASE), 32'(QUAD_OFFSET), 1'b0, 32'(DEPTH));
    assign cos_load         = cos_load_res.next[ADDR_W-1:0];
    assign unused_load_bits = ^{cos_load_res.wrap, cos_load_res.next[31:ADDR_W]};

    // Next-state selection with priority LOAD > EN > hold; strobes default low.
    always_comb begin
        sin_d      = sin_q;
        cos_d      = cos_q;
        wrap_d     = 1'b0;
        load_err_d = 1'b0;
        if (LOAD) begin
            if (load_ok) begin
                sin_d = LOAD_PHASE;
                cos_d = cos_load;
            end else begin
                load_err_d = 1'b1;
            end
        end else if (EN) begin
            sin_d  = sin_next;
            cos_d  = cos_next;
            wrap_d = sin_wrap;
        end
    end

    // Output registers; asynchronous active-low reset abandons the current phase.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            sin_q      <= '0;
            cos_q      <= COS_RESET;
            wrap_q     <= 1'b0;
            load_err_q <= 1'b0;
        end else begin
            sin_q      <= sin_d;
            cos_q      <= cos_d;
            wrap_q     <= wrap_d;
            load_err_q <= load_err_d;
        end
    end

    assign SIN_ADDR = sin_q;
    assign COS_ADDR = cos_q;
    assign WRAP     = wrap_q;
    assign LOAD_ERR = load_err_q;

endmodule
